// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
// Purpose: arbiter state encoding, requester identifiers and default bus widths.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Requester identifiers, also used as the round-robin pointer value.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - two-input round-robin picker
// Purpose: combinational one-hot grant between two requesters.
// Ports:
//   req[1:0]  request vector (bit 0 = core, bit 1 = debug)
//   last      requester granted most recently
//   gnt[1:0]  one-hot grant (all zero when nobody requests)
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | (last == REQ_DBG));
        gnt[1] = req[1] & (~req[0] | (last == REQ_CPU));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin core/debug arbiter for the single-port memory
// Purpose: shares a 1-cycle-latency synchronous memory between the core and the
// debug/loader port, with a debug lock for exclusive multi-word loads.
// Optional feature: define ARB_STARVE_GUARD_EN to grant the stalled core once
// after 15 locked cycles in which it was requesting.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata              core request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid, cpu_rdata     core grant, read-return strobe and data
//   dbg_req/we/addr/wdata, dbg_lock    debug request and exclusive-ownership request
//   dbg_gnt, dbg_rvalid, dbg_rdata     debug grant, read-return strobe and data
//   mem_en/we/addr/wdata, mem_rdata    memory macro interface
//   locked                             debug lock is active
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked
);

    arb_state_e state;
    logic       last_gnt;
    logic       rd_pend;
    logic       rd_owner;
    logic [1:0] pick;
    logic       starve_turn;

    rr_pick2 u_pick (
        .req  ({dbg_req, cpu_req}),
        .last (last_gnt),
        .gnt  (pick)
    );

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign starve_turn = (state == LOCKED) && (starve_cnt == 4'd15);

    // Counts locked cycles in which the core was left waiting; it only lives
    // while the lock is held and restarts after each forced core grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (state != LOCKED || !dbg_lock || starve_turn) begin
            starve_cnt <= 4'd0;
        end else if (cpu_req) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign starve_turn = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches the memory while it is held.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!reset) begin
            if (state == ARB) begin
                cpu_gnt = pick[0];
                dbg_gnt = pick[1];
            end else if (starve_turn) begin
                cpu_gnt = cpu_req;
            end else begin
                dbg_gnt = dbg_req;
            end
        end
    end

    assign mem_en    = cpu_gnt | dbg_gnt;
    assign mem_we    = cpu_gnt ? cpu_we    : (dbg_gnt ? dbg_we    : 1'b0);
    assign mem_addr  = cpu_gnt ? cpu_addr  : (dbg_gnt ? dbg_addr  : '0);
    assign mem_wdata = cpu_gnt ? cpu_wdata : (dbg_gnt ? dbg_wdata : '0);

    assign cpu_rvalid = rd_pend & (rd_owner == REQ_CPU);
    assign dbg_rvalid = rd_pend & (rd_owner == REQ_DBG);
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;
    assign locked     = (state == LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB;
            last_gnt <= REQ_DBG;
            rd_pend  <= 1'b0;
            rd_owner <= REQ_CPU;
        end else begin
            rd_pend  <= mem_en & ~mem_we;
            rd_owner <= dbg_gnt ? REQ_DBG : REQ_CPU;
            if (cpu_gnt) begin
                last_gnt <= REQ_CPU;
            end else if (dbg_gnt) begin
                last_gnt <= REQ_DBG;
            end
            case (state)
                ARB: begin
                    // Lock is taken only on a real debug grant.
                    if (dbg_gnt && dbg_lock) begin
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Leaving the lock hands the next tie to the core.
                    if (!dbg_lock) begin
                        state    <= ARB;
                        last_gnt <= REQ_DBG;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [3:0] cpu_addr, dbg_addr;
    logic [7:0] cpu_wdata, dbg_wdata;
    logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [7:0] cpu_rdata, dbg_rdata;
    logic       mem_en, mem_we, locked;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] tb_mem [16];
    logic [7:0] model_mem [16];
    logic       mem_load = 1'b1;

    typedef struct {
        logic       owner;
        logic [7:0] data;
    } sb_t;
    sb_t sb[$];
    logic rv_due = 1'b0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 17) ^ 8'h3C;
    endfunction

    // Memory macro: synchronous read, one cycle latency.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: inputs are already driven; check at negedge, then
    // update the model/scoreboard and advance to just after the next posedge.
    task automatic step(input string tag, input logic ecg, input logic edg, input logic elk);
        sb_t e;
        logic       exp_we;
        logic [3:0] exp_addr;
        logic [7:0] exp_wdata;
        @(negedge clk);
        exp_we    = ecg ? cpu_we    : (edg ? dbg_we    : 1'b0);
        exp_addr  = ecg ? cpu_addr  : (edg ? dbg_addr  : 4'h0);
        exp_wdata = ecg ? cpu_wdata : (edg ? dbg_wdata : 8'h00);
        chk({tag, "/cpu_gnt"}, 32'(cpu_gnt), 32'(ecg));
        chk({tag, "/dbg_gnt"}, 32'(dbg_gnt), 32'(edg));
        chk({tag, "/mem_en"}, 32'(mem_en), 32'(ecg | edg));
        chk({tag, "/mem_we"}, 32'(mem_we), 32'(exp_we));
        chk({tag, "/mem_addr"}, 32'(mem_addr), 32'(exp_addr));
        chk({tag, "/mem_wdata"}, 32'(mem_wdata), 32'(exp_wdata));
        chk({tag, "/locked"}, 32'(locked), 32'(elk));
        if (rv_due && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "/cpu_rvalid"}, 32'(cpu_rvalid), 32'(!e.owner));
            chk({tag, "/dbg_rvalid"}, 32'(dbg_rvalid), 32'(e.owner));
            chk({tag, "/rdata"}, 32'(e.owner ? dbg_rdata : cpu_rdata), 32'(e.data));
        end else begin
            chk({tag, "/cpu_rvalid"}, 32'(cpu_rvalid), 32'(0));
            chk({tag, "/dbg_rvalid"}, 32'(dbg_rvalid), 32'(0));
        end
        rv_due = 1'b0;
        if (ecg | edg) begin
            if (exp_we) begin
                model_mem[exp_addr] = exp_wdata;
            end else begin
                e.owner = edg;
                e.data  = model_mem[exp_addr];
                sb.push_back(e);
                rv_due = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = init_val(i);
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
        repeat (2) @(posedge clk);
        #1;
        mem_load = 1'b0;

        // Requests during reset are ignored.
        cpu_req = 1; dbg_req = 1;
        step("reset", 0, 0, 0);
        cpu_req = 0; dbg_req = 0;
        reset = 1'b0;

        // Contention right after reset: core first, then alternate.
        cpu_req = 1; cpu_addr = 4'h5; dbg_req = 1; dbg_addr = 4'h6;
        step("cont0", 1, 0, 0);
        step("cont1", 0, 1, 0);
        step("cont2", 1, 0, 0);
        step("cont3", 0, 1, 0);
        cpu_req = 0; dbg_req = 0;
        step("cont_drain", 0, 0, 0);

        // Core only read of address 3.
        cpu_req = 1; cpu_addr = 4'h3;
        step("core_rd", 1, 0, 0);
        cpu_req = 0;
        step("core_rv", 0, 0, 0);

        // Back-to-back reads from different owners.
        cpu_req = 1; cpu_addr = 4'h1;
        step("b2b_cpu", 1, 0, 0);
        cpu_req = 0; dbg_req = 1; dbg_addr = 4'h2;
        step("b2b_dbg", 0, 1, 0);
        dbg_req = 0;
        step("b2b_end", 0, 0, 0);

        // Core write moves the pointer to the core so debug wins the next tie.
        cpu_req = 1; cpu_we = 1; cpu_addr = 4'hF; cpu_wdata = 8'h5A;
        step("cpu_wr", 1, 0, 0);
        cpu_we = 0; cpu_wdata = 0;

        // Locked debug load of 0xA5 into 0x0..0x3 with the core stalled.
        cpu_req = 1; cpu_addr = 4'h0;
        dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_wdata = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 4'(i);
            step("lock_wr", 0, 1, (i != 0));
        end
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_wdata = 0;
        step("lock_rel", 0, 0, 1);
        step("post_lock", 1, 0, 0);
        cpu_req = 0;
        step("post_rv", 0, 0, 0);

        // Reset in the cycle after a granted core read.
        cpu_req = 1; cpu_addr = 4'h7;
        step("rm_rd", 1, 0, 0);
        cpu_req = 0;
        reset = 1'b1;
        sb.delete();
        rv_due = 1'b0;
        step("rm_rst", 0, 0, 0);
        reset = 1'b0;
        cpu_req = 1; cpu_addr = 4'h4; dbg_req = 1; dbg_addr = 4'h4;
        step("rm_tie", 1, 0, 0);
        cpu_req = 0;
        step("rm_tie2", 0, 1, 0);
        dbg_req = 0;
        step("rm_drain", 0, 0, 0);

        // Reset while locked with a read in flight.
        dbg_req = 1; dbg_lock = 1; dbg_addr = 4'h9;
        step("rl_rd", 0, 1, 0);
        dbg_req = 0;
        reset = 1'b1;
        sb.delete();
        rv_due = 1'b0;
        step("rl_rst", 0, 0, 0);
        reset = 1'b0; dbg_lock = 0;
        step("rl_after", 0, 0, 0);

        // Long lock with the core waiting.
        dbg_req = 1; dbg_lock = 1; dbg_addr = 4'h9;
        step("sg_l0", 0, 1, 0);
        cpu_req = 1; cpu_addr = 4'h8;
        for (int k = 1; k <= 15; k++) step("sg_locked", 0, 1, 1);
`ifdef ARB_STARVE_GUARD_EN
        step("sg_cpu", 1, 0, 1);
        cpu_req = 0;
`else
        step("sg_cpu", 0, 1, 1);
`endif
        for (int k = 0; k < 3; k++) step("sg_resume", 0, 1, 1);
        dbg_req = 0; dbg_lock = 0;
        step("sg_rel", 0, 0, 1);
`ifndef ARB_STARVE_GUARD_EN
        step("sg_cpu_late", 1, 0, 0);
        cpu_req = 0;
`endif
        step("final", 0, 0, 0);
        step("final2", 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data memory between the processor core (fetch, LDA/LDB, STR) and a debug/program-loader port.
- Sits between the core's memory interface and the memory macro. Memory has a synchronous read with 1-cycle latency.
- Round-robin arbitration, with an optional debug lock that gives the debug port exclusive ownership for multi-word loads.

Parameters:
- ADDR_W, 4, memory address width
- DATA_W, 8, memory data width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  core access request; held with we/addr/wdata until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  core address
- cpu_wdata  in  DATA_W  core write data
- cpu_gnt  out  1  core access issued this cycle
- cpu_rvalid  out  1  core read data valid
- cpu_rdata  out  DATA_W  core read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  same as the core signals, for the debug port
- dbg_lock  in  1  request exclusive ownership for the debug port
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  same as the core signals, for the debug port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe
- locked  out  1  debug lock state is active

Behaviour:
- State register: ARB, LOCKED. Round-robin pointer last_gnt (0 = cpu, 1 = dbg). rvalid pipeline: rd_pend, rd_owner.
- Reset values: state = ARB, last_gnt = 1 (core wins the first tie), rd_pend = 0.
  - Outputs during reset: all gnt/rvalid/mem_en/mem_we = 0; rdata buses = mem_rdata pass-through (don't-care); locked = 0.
- Grant logic is combinational from the req inputs and registered state. At most one gnt per cycle.
  - mem_en = cpu_gnt | dbg_gnt.
  - mem_we/addr/wdata are muxed from the winner. They are 0 when there is no grant.
- ARB state:
  - Only one req asserted → grant it.
  - Both asserted → grant the requester not equal to last_gnt.
  - On any grant, last_gnt updates at the next clock edge.
- ARB → LOCKED: at the clock edge ending a cycle where dbg_gnt = 1 and dbg_lock = 1.
- LOCKED state:
  - cpu_gnt is forced to 0; the core stalls by holding cpu_req.
  - dbg_req is granted whenever asserted.
  - locked = 1.
- LOCKED → ARB: at the first clock edge where dbg_lock = 0. Release is effective the following cycle.
  - last_gnt = 1 on exit, so the core wins the next tie.
- Read return:
  - A read grant in cycle t sets rd_pend = 1 and rd_owner = winner for cycle t+1.
  - In t+1, the owner's rvalid = 1 and its rdata = mem_rdata.
  - Back-to-back reads are allowed; one result returns per cycle, in issue order.
  - Writes produce no rvalid.
- cpu_rdata and dbg_rdata both carry mem_rdata continuously. Only the rvalid signals qualify the data.
- A requester must not change we/addr/wdata while req = 1 and gnt = 0. Requests dropped before a grant are simply not served.
- Reset asserted mid-operation: an outstanding rvalid is discarded (rd_pend cleared) and LOCKED is exited immediately.
- dbg_lock = 1 with dbg_req = 0 has no effect in ARB. The lock is taken only on an actual debug grant.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- With the macro:
  - A 4-bit counter increments each LOCKED cycle in which cpu_req = 1.
  - When it reaches 15, the next cycle grants the core once (dbg_gnt = 0 that cycle). The counter then clears and the state stays LOCKED.
  - The counter clears on entry to ARB and on reset.
- Without the macro: LOCKED never grants the core, and no counter exists.

Decomposition:
- Shared package (existing processor package):
  - typedef arb_state_e {ARB, LOCKED}
  - constants REQ_CPU = 0, REQ_DBG = 1
  - default ADDR_W/DATA_W values
- Sub-module rr_pick2: 2-input round-robin picker (req[1:0], last, gnt[1:0]), purely combinational.
- Everything else lives in mem_port_arbiter.

Test Plan:
- Core only: cpu read addr 0x3 → cpu_gnt same cycle, mem_en = 1, mem_addr = 3. Next cycle cpu_rvalid = 1 with rdata = memory[3]. dbg_rvalid stays 0.
- Contention: both req for 4 consecutive cycles right after reset → grants alternate cpu, dbg, cpu, dbg, and exactly one gnt per cycle.
- Back-to-back: cpu read 0x1, then dbg read 0x2 → rvalid for cpu then dbg in consecutive cycles, with the correct data and no overlap.
- Lock: dbg writes 0xA5 to 0x0..0x3 with dbg_lock = 1 while cpu_req is held → cpu_gnt = 0 throughout and locked = 1. dbg_lock falls → core granted within 2 cycles and reads 0xA5 at 0x0.
- Reset mid-read: assert reset in the cycle after a granted read → no rvalid, locked = 0, state = ARB. After release, core wins the first tie.
- ARB_STARVE_GUARD_EN: lock held with dbg_req continuous and cpu_req asserted → one cpu_gnt after 15 locked cycles, then debug grants resume. Without the macro: zero cpu_gnt.
